// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and VRAM access-source type
package vga_pkg;
  localparam int HVA  = 640;
  localparam int VVA  = 480;
  localparam int HCNT = 800;
  localparam int VCNT = 525;

  typedef enum logic {
    SRC_DISP = 1'b0,
    SRC_HOST = 1'b1
  } src_e;
endpackage

// File: rtl/vga_vram_mem.sv
// rtl/vga_vram_mem.sv - single-port synchronous pixel RAM, one-cycle read, write-first
module vga_vram_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 307200,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/vga_vram_ctrl.sv
// rtl/vga_vram_ctrl.sv - VRAM responder: host/display arbiter, address pipeline, fixed-latency return
module vga_vram_ctrl #(
  parameter int PWIDTH     = 8,
  parameter int LATENCY    = 4,
  parameter int HVA        = vga_pkg::HVA,
  parameter int VVA        = vga_pkg::VVA,
  parameter int HWIDTH     = 10,
  parameter int VWIDTH     = 10,
  parameter int AWIDTH     = HWIDTH + VWIDTH,
  parameter int HOST_BURST = 8
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic              vram_rd,
  input  logic [AWIDTH-1:0] vram_addr,
  output logic              vram_busy,
  output logic [PWIDTH-1:0] vram_data,
  output logic              vram_vld,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [PWIDTH-1:0] host_wdata,
  output logic              host_ready,
  output logic [PWIDTH-1:0] host_rdata,
  output logic              host_rvld,
  output logic              addr_err
);
  import vga_pkg::*;

  localparam int DEPTH  = HVA * VVA;
  localparam int LWIDTH = $clog2(DEPTH);
  localparam int CWIDTH = $clog2(HOST_BURST + 1);
  localparam int NDLY   = LATENCY - 2;

  typedef struct packed {
    logic              valid;
    src_e              src;
    logic              we;
    logic              oor;
    logic [PWIDTH-1:0] data;
  } dly_t;

  logic [CWIDTH-1:0] r_starve_cnt;
  logic              w_force_disp, w_host_gnt, w_disp_gnt;

  // vram_busy deliberately ignores vram_rd: the initiator derives vram_rd from it
  assign w_force_disp = (r_starve_cnt == CWIDTH'(HOST_BURST));
  assign w_host_gnt   = host_req & ~w_force_disp & ~rst_core;
  assign w_disp_gnt   = vram_rd & ~w_host_gnt & ~rst_core;
  assign vram_busy    = w_host_gnt;
  assign host_ready   = w_host_gnt;

  logic              r_s0_valid, r_s0_we;
  src_e              r_s0_src;
  logic [AWIDTH-1:0] r_s0_addr;
  logic [PWIDTH-1:0] r_s0_wdata;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_starve_cnt <= '0;
      r_s0_valid   <= 1'b0;
    end else begin
      r_starve_cnt <= w_host_gnt ? r_starve_cnt + CWIDTH'(1) : '0;
      r_s0_valid   <= w_host_gnt | w_disp_gnt;
    end
    r_s0_src   <= w_host_gnt ? SRC_HOST : SRC_DISP;
    r_s0_we    <= w_host_gnt & host_we;
    r_s0_addr  <= w_host_gnt ? host_addr : vram_addr;
    r_s0_wdata <= host_wdata;
  end

  logic [VWIDTH-1:0] w_v;
  logic [HWIDTH-1:0] w_h;
  logic              w_oor;
  logic [LWIDTH-1:0] w_lin;

  assign w_v   = r_s0_addr[AWIDTH-1:HWIDTH];
  assign w_h   = r_s0_addr[HWIDTH-1:0];
  assign w_oor = (int'(w_h) >= HVA) || (int'(w_v) >= VVA);

  // 640 = 512 + 128, so the default geometry needs only two shifts and adds
  if (HVA == 640) begin : g_lin_shift
    assign w_lin = (LWIDTH'(w_v) << 9) + (LWIDTH'(w_v) << 7) + LWIDTH'(w_h);
  end else begin : g_lin_mul
    assign w_lin = LWIDTH'(int'(w_v) * HVA + int'(w_h));
  end

  logic              r_s1_valid, r_s1_we, r_s1_oor;
  src_e              r_s1_src;
  logic [LWIDTH-1:0] r_s1_lin;
  logic [PWIDTH-1:0] r_s1_wdata;

  always_ff @(posedge clk_core) begin
    if (rst_core) r_s1_valid <= 1'b0;
    else          r_s1_valid <= r_s0_valid;
    r_s1_src   <= r_s0_src;
    r_s1_we    <= r_s0_we;
    r_s1_oor   <= w_oor;
    r_s1_lin   <= w_lin;
    r_s1_wdata <= r_s0_wdata;
  end

  assign addr_err = r_s1_valid & r_s1_oor;

  logic              w_mem_we;
  logic [LWIDTH-1:0] w_mem_addr;
  logic [PWIDTH-1:0] w_mem_rdata;

  // an out-of-range access never touches the array; its read uses a safe index and is zeroed later
  assign w_mem_we   = r_s1_valid & r_s1_we & ~r_s1_oor & ~rst_core;
  assign w_mem_addr = r_s1_oor ? '0 : r_s1_lin;

  vga_vram_mem #(
    .DW   (PWIDTH),
    .DEPTH(DEPTH),
    .AW   (LWIDTH)
  ) u_mem (
    .clk    (clk_core),
    .i_we   (w_mem_we),
    .i_addr (w_mem_addr),
    .i_wdata(r_s1_wdata),
    .o_rdata(w_mem_rdata)
  );

  logic r_s2_valid, r_s2_we, r_s2_oor;
  src_e r_s2_src;

  always_ff @(posedge clk_core) begin
    if (rst_core) r_s2_valid <= 1'b0;
    else          r_s2_valid <= r_s1_valid;
    r_s2_src <= r_s1_src;
    r_s2_we  <= r_s1_we;
    r_s2_oor <= r_s1_oor;
  end

  dly_t w_dly_in;
  dly_t r_dly [NDLY];
  dly_t w_last;

  always_comb begin
    w_dly_in       = '0;
    w_dly_in.valid = r_s2_valid;
    w_dly_in.src   = r_s2_src;
    w_dly_in.we    = r_s2_we;
    w_dly_in.oor   = r_s2_oor;
    w_dly_in.data  = (r_s2_oor | r_s2_we) ? '0 : w_mem_rdata;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      for (int k = 0; k < NDLY; k++) r_dly[k] <= '0;
    end else begin
      r_dly[0] <= w_dly_in;
      for (int k = 1; k < NDLY; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign w_last     = r_dly[NDLY-1];
  assign vram_vld   = w_last.valid & ~w_last.we & (w_last.src == SRC_DISP);
  assign host_rvld  = w_last.valid & ~w_last.we & (w_last.src == SRC_HOST);
  assign vram_data  = vram_vld  ? w_last.data : '0;
  assign host_rdata = host_rvld ? w_last.data : '0;
endmodule
